// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with return-address stack
//
// Purpose: holds the fetch PC, advances it on accepted control instructions,
// redirects on jumps/calls/returns with a one-cycle flush bubble, and keeps a
// circular return-address stack.
//
// Optional feature macro: STACK_FAULT_EN
//   defined   : push on full / pop on empty halts the sequencer and latches fault
//   undefined : push on full overwrites the oldest entry, pop on empty yields
//               RESET_VECTOR; HALT is unreachable and fault stays 0
//
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   instr_valid/ready control-instruction handshake from decode
//   jump_immediate    taken-branch decision
//   is_call/is_return call (with jump_immediate) / return qualifiers
//   immediate         jump/call target
//   fetch_ready       fetch unit can take a new PC
//   pc, pc_valid      current fetch address and its qualifier
//   flush             one-cycle pulse to drop in-flight fetches
//   depth             return-stack occupancy
//   fault             latched stack fault
module pc_sequencer #(
  parameter int                    WORD_WIDTH   = 32,
  parameter int                    STACK_DEPTH  = 8,
  parameter logic [WORD_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           instr_valid,
  output logic                           instr_ready,
  input  logic                           jump_immediate,
  input  logic                           is_call,
  input  logic                           is_return,
  input  logic [WORD_WIDTH-1:0]          immediate,
  input  logic                           fetch_ready,
  output logic [WORD_WIDTH-1:0]          pc,
  output logic                           pc_valid,
  output logic                           flush,
  output logic [$clog2(STACK_DEPTH):0]   depth,
  output logic                           fault
);

  localparam int PW = $clog2(STACK_DEPTH);
  localparam int DW = PW + 1;

`ifdef STACK_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [WORD_WIDTH-1:0] pc_q, pc_d;
  logic                  flush_q, flush_d;
  logic                  fault_q, fault_d;
  logic [DW-1:0]         depth_q, depth_d;
  // top_q points at the slot the next push writes; it wraps freely so that a
  // push on a full stack overwrites the oldest entry.
  logic [PW-1:0]         top_q, top_d;
  logic [WORD_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic                  transfer;
  logic                  push_en;
  logic                  full;
  logic                  empty;
  logic [PW-1:0]         top_m1;
  logic [WORD_WIDTH-1:0] pc_inc;

  assign instr_ready = (state_q == ST_RUN) & fetch_ready;
  assign pc_valid    = (state_q == ST_RUN);
  assign pc          = pc_q;
  assign flush       = flush_q;
  assign depth       = depth_q;
  assign fault       = fault_q;

  assign transfer = instr_valid & instr_ready;
  assign full     = (depth_q == DW'(STACK_DEPTH));
  assign empty    = (depth_q == '0);
  assign top_m1   = top_q - PW'(1);
  assign pc_inc   = pc_q + WORD_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = 1'b0;
    fault_d = fault_q;
    depth_d = depth_q;
    top_d   = top_q;
    push_en = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (transfer) begin
          if (jump_immediate) begin
            // Jump wins over is_return; a call only counts with a jump.
            if (is_call && full && FAULT_EN) begin
              state_d = ST_HALT;
              fault_d = 1'b1;
              flush_d = 1'b1;
            end else begin
              if (is_call) begin
                push_en = 1'b1;
                top_d   = top_q + PW'(1);
                if (!full) depth_d = depth_q + DW'(1);
              end
              pc_d    = immediate;
              flush_d = 1'b1;
              state_d = ST_REDIRECT;
            end
          end else if (is_return) begin
            if (empty && FAULT_EN) begin
              state_d = ST_HALT;
              fault_d = 1'b1;
              flush_d = 1'b1;
            end else if (empty) begin
              pc_d    = RESET_VECTOR;
              flush_d = 1'b1;
              state_d = ST_REDIRECT;
            end else begin
              pc_d    = stack_q[top_m1];
              top_d   = top_m1;
              depth_d = depth_q - DW'(1);
              flush_d = 1'b1;
              state_d = ST_REDIRECT;
            end
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      ST_REDIRECT: state_d = ST_RUN;
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VECTOR;
      flush_q <= 1'b0;
      fault_q <= 1'b0;
      depth_q <= '0;
      top_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      fault_q <= fault_d;
      depth_q <= depth_d;
      top_q   <= top_d;
    end
  end

  // Stack contents need no reset; occupancy is tracked by depth_q.
  always_ff @(posedge clk) begin
    if (reset_n && push_en) begin
      stack_q[top_q] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

  localparam int SD = 8;

`ifdef STACK_FAULT_EN
  localparam bit M_FAULT = 1'b1;
`else
  localparam bit M_FAULT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        jump_immediate = 1'b0;
  logic        is_call = 1'b0;
  logic        is_return = 1'b0;
  logic [31:0] immediate = '0;
  logic        fetch_ready = 1'b1;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic [3:0]  depth;
  logic        fault;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  pc_sequencer dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .jump_immediate(jump_immediate), .is_call(is_call), .is_return(is_return),
    .immediate(immediate), .fetch_ready(fetch_ready), .pc(pc), .pc_valid(pc_valid),
    .flush(flush), .depth(depth), .fault(fault)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0=running, 1=bubble, 2=halted; stack as a queue.
  int          m_mode = 0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_stack[$];
  bit          m_flush = 1'b0;
  bit          m_fault = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_mode = 0; m_pc = 32'h0; m_stack.delete(); m_flush = 0; m_fault = 0;
    end else begin
      m_flush = 0;
      if (m_mode == 1) m_mode = 0;
      else if (m_mode == 0 && instr_valid && fetch_ready) begin
        if (jump_immediate) begin
          if (is_call && M_FAULT && m_stack.size() == SD) begin
            m_mode = 2; m_fault = 1; m_flush = 1;
          end else begin
            if (is_call) begin
              m_stack.push_back(m_pc + 32'd1);
              if (m_stack.size() > SD) m_stack.delete(0);
            end
            m_pc = immediate; m_flush = 1; m_mode = 1;
          end
        end else if (is_return) begin
          if (m_stack.size() == 0 && M_FAULT) begin
            m_mode = 2; m_fault = 1; m_flush = 1;
          end else begin
            m_pc = (m_stack.size() == 0) ? 32'h0 : m_stack.pop_back();
            m_flush = 1; m_mode = 1;
          end
        end else begin
          m_pc = m_pc + 32'd1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_pc",       64'(pc),          64'(m_pc));
      chk("m_pc_valid", 64'(pc_valid),    64'(m_mode == 0));
      chk("m_ready",    64'(instr_ready), 64'((m_mode == 0) && fetch_ready));
      chk("m_flush",    64'(flush),       64'(m_flush));
      chk("m_depth",    64'(depth),       64'(m_stack.size()));
      chk("m_fault",    64'(fault),       64'(m_fault));
    end
  end

  task automatic step(input logic v, input logic j, input logic c, input logic r,
                      input logic [31:0] imm, input logic fr);
    instr_valid = v; jump_immediate = j; is_call = c; is_return = r;
    immediate = imm; fetch_ready = fr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    chk_en = 1'b1;
    idle();
    chk("rst_pc", 64'(pc), 64'h0);
    chk("rst_valid", 64'(pc_valid), 64'h1);
    chk("rst_depth", 64'(depth), 64'h0);
    chk("rst_fault", 64'(fault), 64'h0);
    reset_n = 1'b1;

    // Sequential advance
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 32'h0, 1);
    chk("seq_pc3", 64'(pc), 64'h3);

    // Jump at 0x10 to 0x80
    step(1, 1, 0, 0, 32'h10, 1);
    idle();
    chk("pre_jump_pc", 64'(pc), 64'h10);
    step(1, 1, 0, 0, 32'h80, 1);
    chk("jump_flush", 64'(flush), 64'h1);
    chk("jump_bubble", 64'(pc_valid), 64'h0);
    idle();
    chk("jump_pc", 64'(pc), 64'h80);
    chk("jump_valid", 64'(pc_valid), 64'h1);

    // Call at 0x20 to 0x100, return at 0x105
    step(1, 1, 0, 0, 32'h20, 1);
    idle();
    step(1, 1, 1, 0, 32'h100, 1);
    chk("call_depth", 64'(depth), 64'h1);
    idle();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 32'h0, 1);
    chk("pre_ret_pc", 64'(pc), 64'h105);
    step(1, 0, 0, 1, 32'h0, 1);
    chk("ret_depth", 64'(depth), 64'h0);
    idle();
    chk("ret_pc", 64'(pc), 64'h21);

    // Fetch stall
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 32'h0, 0);
      chk("stall_ready", 64'(instr_ready), 64'h0);
      chk("stall_pc", 64'(pc), 64'h21);
    end
    step(1, 0, 0, 0, 32'h0, 1);
    chk("resume_pc", 64'(pc), 64'h22);

    // Jump with is_return at depth 2
    step(1, 1, 1, 0, 32'h200, 1); idle();
    step(1, 1, 1, 0, 32'h300, 1); idle();
    step(1, 1, 0, 1, 32'h40, 1);
    chk("jr_depth", 64'(depth), 64'h2);
    idle();
    chk("jr_pc", 64'(pc), 64'h40);
    step(1, 0, 0, 1, 32'h0, 1); idle();
    chk("pop2_pc", 64'(pc), 64'h201);
    step(1, 0, 0, 1, 32'h0, 1); idle();
    chk("pop1_pc", 64'(pc), 64'h23);

    // Nine nested calls on an eight-entry stack
    for (int k = 0; k < 8; k++) begin
      step(1, 1, 1, 0, 32'h1000 + 32'(k) * 32'h10, 1);
      idle();
    end
    chk("full_depth", 64'(depth), 64'h8);
    step(1, 1, 1, 0, 32'h1080, 1);
`ifdef STACK_FAULT_EN
    chk("fault_set", 64'(fault), 64'h1);
    chk("fault_flush", 64'(flush), 64'h1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 32'h0, 1);
      chk("halt_pc", 64'(pc), 64'h1070);
      chk("halt_ready", 64'(instr_ready), 64'h0);
      chk("halt_fault", 64'(fault), 64'h1);
    end
    reset_n = 1'b0; idle(); reset_n = 1'b1;
    chk("fault_clear", 64'(fault), 64'h0);
    chk("fault_rst_pc", 64'(pc), 64'h0);
`else
    chk("ovf_depth", 64'(depth), 64'h8);
    idle();
    chk("ovf_pc", 64'(pc), 64'h1080);
    for (int k = 0; k < 9; k++) begin
      step(1, 0, 0, 1, 32'h0, 1);
      idle();
      if (k == 0) chk("ret1_pc", 64'(pc), 64'h1071);
      if (k == 7) chk("ret8_pc", 64'(pc), 64'h1001);
    end
    chk("ret9_pc", 64'(pc), 64'h0);
    chk("ret9_depth", 64'(depth), 64'h0);
`endif

    // PC wrap and call without jump
    step(1, 1, 0, 0, 32'hFFFF_FFFF, 1); idle();
    chk("wrap_pre", 64'(pc), 64'hFFFF_FFFF);
    step(1, 0, 0, 0, 32'h0, 1);
    chk("wrap_pc", 64'(pc), 64'h0);
    step(1, 0, 1, 0, 32'h55, 1);
    chk("nojmp_call_pc", 64'(pc), 64'h1);
    chk("nojmp_call_flush", 64'(flush), 64'h0);

    // Reset during the redirect bubble
    step(1, 1, 0, 0, 32'h77, 1);
    chk("mid_flush", 64'(flush), 64'h1);
    reset_n = 1'b0; idle(); reset_n = 1'b1;
    chk("mid_rst_pc", 64'(pc), 64'h0);
    chk("mid_rst_valid", 64'(pc_valid), 64'h1);
    chk("mid_rst_flush", 64'(flush), 64'h0);
    idle();
    idle();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
